// File: rtl/fill_buffer_pkg.sv
// rtl/fill_buffer_pkg.sv - shared types and constants for the line fill buffer
package fill_buffer_pkg;

    localparam int WORD_W    = 16;
    localparam int NUM_WORDS = 8;
    localparam int OFFSET_W  = 3;

    typedef logic [WORD_W-1:0] line_word_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        FILL = 2'd1,
        DONE = 2'd2
    } fill_state_t;

endpackage

// File: rtl/fill_buffer_if.sv
// rtl/fill_buffer_if.sv - memory beat handshake between physical memory and the fill buffer
interface fill_buffer_if #(
    parameter int WORD_W = fill_buffer_pkg::WORD_W
);

    logic              mem_valid;
    logic [WORD_W-1:0] mem_rdata;
    logic              mem_ready;

    modport master (output mem_valid, output mem_rdata, input mem_ready);
    modport slave  (input mem_valid, input mem_rdata, output mem_ready);

endinterface

// File: rtl/fill_index_gen.sv
// rtl/fill_index_gen.sv - beat counter and wrap-order write index for one line fill
module fill_index_gen
    import fill_buffer_pkg::*;
(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    input  logic [OFFSET_W-1:0] offset,
    input  logic                advance,
    input  logic                clear,
    output logic [OFFSET_W-1:0] wr_idx,
    output logic                first_beat,
    output logic                last_beat
);

    logic [OFFSET_W-1:0] beat_cnt;
    logic [OFFSET_W-1:0] start_off;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            beat_cnt  <= '0;
            start_off <= '0;
        end else if (start) begin
            beat_cnt  <= '0;
            start_off <= offset;
        end else if (clear) begin
            beat_cnt  <= '0;
        end else if (advance) begin
            beat_cnt  <= beat_cnt + 1'b1;
        end
    end

    // 3-bit add wraps naturally, giving critical-word-first order
    assign wr_idx     = start_off + beat_cnt;
    assign first_beat = (beat_cnt == '0);
    assign last_beat  = (beat_cnt == OFFSET_W'(NUM_WORDS - 1));

endmodule

// File: rtl/fill_buffer.sv
// rtl/fill_buffer.sv - collects an 8-word line in wrap order and presents it to the word-select mux
module fill_buffer #(
    parameter int WORD_W = 16
) (
    input  logic                                clk,
    input  logic                                rst_n,
    input  logic                                fill_req,
    input  logic [fill_buffer_pkg::OFFSET_W-1:0] fill_offset,
    fill_buffer_if.slave                        mem,
    input  logic                                abort,
    input  logic                                invalidate,
    output logic [WORD_W-1:0]                   word0,
    output logic [WORD_W-1:0]                   word1,
    output logic [WORD_W-1:0]                   word2,
    output logic [WORD_W-1:0]                   word3,
    output logic [WORD_W-1:0]                   word4,
    output logic [WORD_W-1:0]                   word5,
    output logic [WORD_W-1:0]                   word6,
    output logic [WORD_W-1:0]                   word7,
    output logic [fill_buffer_pkg::NUM_WORDS-1:0] valid_mask,
    output logic                                crit_valid,
    output logic                                done,
    output logic                                line_valid,
    output logic                                busy
);

    import fill_buffer_pkg::*;

    localparam logic [1:0] ST_IDLE = IDLE;
    localparam logic [1:0] ST_FILL = FILL;
    localparam logic [1:0] ST_DONE = DONE;

    logic [1:0]          state;
    logic [WORD_W-1:0]   words [NUM_WORDS];
    logic [OFFSET_W-1:0] wr_idx;
    logic                first_beat;
    logic                last_beat;
    logic                in_fill;
    logic                can_start;
    logic                beat_ok;
    logic                abort_fill;
    logic                drop_line;

    assign in_fill    = (state == ST_FILL);
    assign can_start  = fill_req && ((state == ST_IDLE) || (state == ST_DONE));
    // abort beats an accepted beat in the same cycle, so the beat is dropped
    assign beat_ok    = in_fill && mem.mem_valid && !abort;
    assign abort_fill = in_fill && abort;
    assign drop_line  = (state == ST_DONE) && invalidate && !fill_req;

    fill_index_gen u_index (
        .clk        (clk),
        .rst_n      (rst_n),
        .start      (can_start),
        .offset     (fill_offset),
        .advance    (beat_ok),
        .clear      (abort_fill),
        .wr_idx     (wr_idx),
        .first_beat (first_beat),
        .last_beat  (last_beat)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= ST_IDLE;
            valid_mask <= '0;
            crit_valid <= 1'b0;
            done       <= 1'b0;
            line_valid <= 1'b0;
        end else begin
            crit_valid <= beat_ok && first_beat;
            done       <= beat_ok && last_beat;

            case (state)
                ST_IDLE: if (fill_req) state <= ST_FILL;
                ST_FILL: begin
                    if (abort)                      state <= ST_IDLE;
                    else if (beat_ok && last_beat)  state <= ST_DONE;
                end
                ST_DONE: begin
                    if (fill_req)        state <= ST_FILL;
                    else if (invalidate) state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase

            if (can_start || abort_fill || drop_line)
                valid_mask <= '0;
            else if (beat_ok)
                valid_mask <= valid_mask | (NUM_WORDS'(1) << wr_idx);

            if (beat_ok && last_beat)
                line_valid <= 1'b1;
            else if (can_start || drop_line)
                line_valid <= 1'b0;
        end
    end

    // word data survives abort and invalidate; only the mask says what is current
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_WORDS; i++) words[i] <= '0;
        end else if (beat_ok) begin
            words[wr_idx] <= mem.mem_rdata;
        end
    end

    assign busy          = in_fill;
    assign mem.mem_ready = in_fill;

    assign word0 = words[0];
    assign word1 = words[1];
    assign word2 = words[2];
    assign word3 = words[3];
    assign word4 = words[4];
    assign word5 = words[5];
    assign word6 = words[6];
    assign word7 = words[7];

endmodule

// File: doc/fill_buffer.md
Name: fill_buffer

Overview:
Line fill buffer upstream of the cache-line word-select mux8. It collects eight 16-bit words from physical memory, one per accepted beat, in critical-word-first wrap order, and holds them as eight parallel word outputs (word0..word7) that drive the mux8 a..h inputs. A per-word valid mask and a critical-word pulse let the pipeline forward the requested word before the line is complete.

Parameters:
WORD_W, 16, width of each word and of mem_rdata
NUM_WORDS, 8, words per line; fixed at 8 to match mux8; OFFSET_W = 3 derived

Ports:
clk  input  1  clock; all state updates on its rising edge
rst_n  input  1  asynchronous, active-low reset
fill_req  input  1  start a fill; sampled only in IDLE or DONE
fill_offset  input  3  critical word index, sampled with fill_req
mem_valid  input  1  memory beat present on mem_rdata
mem_rdata  input  WORD_W  memory beat data
mem_ready  output  1  buffer accepts a beat this cycle; beat accepted = mem_valid & mem_ready
abort  input  1  cancel the current fill
invalidate  input  1  drop a completed line
word0..word7  output  WORD_W each  buffered words, to mux8 a..h
valid_mask  output  8  bit i set when word i has been written in the current fill
crit_valid  output  1  one-cycle pulse when the critical word is written
done  output  1  one-cycle pulse when the 8th beat is written
line_valid  output  1  full line held
busy  output  1  FSM in FILL

Behaviour:
- Reset (async, rst_n=0): state=IDLE; word0..7=0; valid_mask=0; beat_cnt=0; start_off=0; crit_valid=0; done=0; line_valid=0; busy=0; mem_ready=0.
- States:
  - IDLE -> FILL on fill_req. In that cycle, latch start_off=fill_offset, clear valid_mask and beat_cnt, and clear line_valid.
  - FILL: mem_ready=1 and busy=1. On each accepted beat, write word[(start_off+beat_cnt) mod 8] and set its valid_mask bit. Index arithmetic is 3-bit, so wrap is natural. beat_cnt increments.
  - The beat with beat_cnt==0 is the critical word. crit_valid pulses in the cycle after it is accepted, with the word already visible on its output.
  - The beat with beat_cnt==7 causes FILL -> DONE. done and line_valid assert in the following cycle; done lasts one cycle.
  - DONE: line_valid=1 and mem_ready=0. invalidate -> IDLE (line_valid=0, valid_mask=0). fill_req -> FILL as from IDLE. If fill_req and invalidate arrive together, fill_req wins.
- All outputs are registered. Write latency from beat accept to visible word, mask bit and pulse is 1 cycle.
- fill_req in FILL is ignored, with no restart. invalidate in FILL or IDLE is ignored.
- abort in FILL -> IDLE next cycle: valid_mask=0, beat_cnt=0, no done, no crit_valid. abort in IDLE or DONE is ignored.
- If abort and an accepted beat occur in the same cycle, abort wins and the beat is discarded with no word write. This holds even on beat 7.
- mem_valid outside FILL is ignored, since mem_ready=0.
- Word data is not cleared on abort or invalidate; only valid_mask and line_valid are cleared.
- Gaps between beats (mem_valid low) are unbounded; state holds.
- Reset mid-fill returns everything to reset values immediately.

Decomposition:
- A shared package holds:
  - the fill_state_t enum {IDLE, FILL, DONE}
  - the constants NUM_WORDS=8 and OFFSET_W=3
  - the typedef line_word_t = logic [WORD_W-1:0]
- One natural sub-module is fill_index_gen: 3-bit beat counter plus start offset adder producing the write index and last-beat flag.
- The word registers and FSM stay in fill_buffer.

Test Plan:
- Reset, then fill_offset=0 with beats 0x1000..0x1007 back-to-back -> word0..7 = 0x1000..0x1007. crit_valid pulses 1 cycle after the first beat. done and line_valid are high 1 cycle after the 8th beat. valid_mask=8'hFF.
- fill_offset=5 with beats 0xA0..0xA7 -> word5=0xA0, word6=0xA1, word7=0xA2, word0=0xA3 … word4=0xA7. Immediately after the first beat, valid_mask=8'h20.
- Same fill with mem_valid low for 3 cycles between each beat -> identical final words; busy stays 1 throughout; done is a single pulse.
- abort asserted together with the 4th accepted beat, fill_offset=2 -> valid_mask=8'h1C, then 0 next cycle. Word5 is not updated, and done and line_valid never assert.
- After a completed line, drive fill_req and invalidate in the same cycle -> a new fill starts (busy=1, line_valid=0); a later invalidate during FILL has no effect.
- Deassert rst_n asynchronously mid-fill (between clock edges) -> all outputs are 0 without waiting for a clock edge. A subsequent fill_req starts a clean fill.
